// File: rtl/plab4_net_router_input_queue_dual_domain_if.sv
// Handshake bundle between the upstream link, the dual-domain input queue and the
// input-ctrl arbiter: enqueue side and dequeue head for each of the two security domains.
interface plab4_net_router_input_queue_dual_domain_if #(
  parameter int p_msg_nbits   = 44,
  parameter int p_num_routers = 8
);
  localparam int c_dest_nbits = $clog2(p_num_routers);

  logic [p_msg_nbits-1:0]  enq_msg_d0;
  logic                    enq_val_d0;
  logic                    enq_rdy_d0;
  logic [p_msg_nbits-1:0]  enq_msg_d1;
  logic                    enq_val_d1;
  logic                    enq_rdy_d1;
  logic [p_msg_nbits-1:0]  deq_msg_d0;
  logic [c_dest_nbits-1:0] deq_dest_d0;
  logic                    deq_val_d0;
  logic                    deq_rdy_d0;
  logic [p_msg_nbits-1:0]  deq_msg_d1;
  logic [c_dest_nbits-1:0] deq_dest_d1;
  logic                    deq_val_d1;
  logic                    deq_rdy_d1;

  modport master (
    output enq_msg_d0, enq_val_d0, enq_msg_d1, enq_val_d1, deq_rdy_d0, deq_rdy_d1,
    input  enq_rdy_d0, enq_rdy_d1, deq_msg_d0, deq_dest_d0, deq_val_d0,
           deq_msg_d1, deq_dest_d1, deq_val_d1
  );

  modport slave (
    input  enq_msg_d0, enq_val_d0, enq_msg_d1, enq_val_d1, deq_rdy_d0, deq_rdy_d1,
    output enq_rdy_d0, enq_rdy_d1, deq_msg_d0, deq_dest_d0, deq_val_d0,
           deq_msg_d1, deq_dest_d1, deq_val_d1
  );
endinterface

// File: rtl/plab4_net_router_input_queue_dual_domain.sv
// Router input buffer with two fully isolated FIFOs (one per security domain) whose
// heads feed the input-ctrl arbiter. No bypass and no pipe-through on either FIFO.
module plab4_net_router_input_queue_dual_domain #(
  parameter int p_msg_nbits   = 44,
  parameter int p_num_routers = 8,
  parameter int p_num_entries = 4
) (
  input  logic clk,
  input  logic reset,
  plab4_net_router_input_queue_dual_domain_if.slave q
);
  localparam int c_dest_nbits = $clog2(p_num_routers);
  localparam int c_addr_nbits = $clog2(p_num_entries);
  localparam int c_cnt_nbits  = c_addr_nbits + 1;
  localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_entries);

  logic [p_msg_nbits-1:0] enq_msg_s [2];
  logic                   enq_val_s [2];
  logic                   deq_rdy_s [2];
  logic                   enq_rdy_s [2];
  logic                   deq_val_s [2];
  logic [p_msg_nbits-1:0] deq_msg_s [2];

  assign enq_msg_s[0] = q.enq_msg_d0;
  assign enq_msg_s[1] = q.enq_msg_d1;
  assign enq_val_s[0] = q.enq_val_d0;
  assign enq_val_s[1] = q.enq_val_d1;
  assign deq_rdy_s[0] = q.deq_rdy_d0;
  assign deq_rdy_s[1] = q.deq_rdy_d1;

  assign q.enq_rdy_d0  = enq_rdy_s[0];
  assign q.enq_rdy_d1  = enq_rdy_s[1];
  assign q.deq_val_d0  = deq_val_s[0];
  assign q.deq_val_d1  = deq_val_s[1];
  assign q.deq_msg_d0  = deq_msg_s[0];
  assign q.deq_msg_d1  = deq_msg_s[1];
  assign q.deq_dest_d0 = deq_msg_s[0][p_msg_nbits-1 -: c_dest_nbits];
  assign q.deq_dest_d1 = deq_msg_s[1][p_msg_nbits-1 -: c_dest_nbits];

  // One independent FIFO per domain; nothing in here crosses between domains.
  for (genvar d = 0; d < 2; d++) begin : g_dom
    logic [p_msg_nbits-1:0]  mem_r [p_num_entries];
    logic [c_addr_nbits-1:0] wr_ptr_r;
    logic [c_addr_nbits-1:0] rd_ptr_r;
    logic [c_cnt_nbits-1:0]  count_r;
    logic                    enq_fire_s;
    logic                    deq_fire_s;

    // Ready/valid depend only on the count, so a dequeue never frees a full slot early.
    assign enq_rdy_s[d] = (count_r != c_full);
    assign deq_val_s[d] = (count_r != c_cnt_nbits'(0));
    assign enq_fire_s   = enq_val_s[d] & enq_rdy_s[d];
    assign deq_fire_s   = deq_val_s[d] & deq_rdy_s[d];
    assign deq_msg_s[d] = deq_val_s[d] ? mem_r[rd_ptr_r] : {p_msg_nbits{1'b0}};

    // Pointer and occupancy state; async reset discards everything queued.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr_r <= c_addr_nbits'(0);
        rd_ptr_r <= c_addr_nbits'(0);
        count_r  <= c_cnt_nbits'(0);
      end else begin
        if (enq_fire_s) wr_ptr_r <= wr_ptr_r + c_addr_nbits'(1);
        if (deq_fire_s) rd_ptr_r <= rd_ptr_r + c_addr_nbits'(1);
        case ({enq_fire_s, deq_fire_s})
          2'b10:   count_r <= count_r + c_cnt_nbits'(1);
          2'b01:   count_r <= count_r - c_cnt_nbits'(1);
          default: count_r <= count_r;
        endcase
      end
    end

    // Payload storage; left unreset because the head is masked while empty.
    always_ff @(posedge clk) begin
      if (enq_fire_s) mem_r[wr_ptr_r] <= enq_msg_s[d];
    end
  end
endmodule

// File: tb/tb_plab4_net_router_input_queue_dual_domain.sv
// Directed bench for the dual-domain router input queue: reset, ordering, full/empty,
// wrap-around, domain isolation and asynchronous reset while traffic is queued.
module tb_plab4_net_router_input_queue_dual_domain;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  int tag = 0;
  logic [43:0] q0[$];
  logic [43:0] q1[$];
  logic [39:0] tr_a;
  logic [39:0] tr_b;
  bit p_ev0 [40];
  bit p_dr0 [40];

  plab4_net_router_input_queue_dual_domain_if #(.p_msg_nbits(44), .p_num_routers(8)) bus ();

  plab4_net_router_input_queue_dual_domain #(
    .p_msg_nbits(44), .p_num_routers(8), .p_num_entries(4)
  ) dut (
    .clk(clk), .reset(reset), .q(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [43:0] mk(input int dest, input int t);
    return {3'(dest), 41'(t)};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One cycle of scoreboarded traffic on both domains; rec selects trace capture.
  task automatic step2(input bit ev0, input bit dr0, input bit ev1, input bit dr1,
                       input int idx, input int rec);
    logic [43:0] m0;
    logic [43:0] m1;
    logic [43:0] h0;
    logic [43:0] h1;
    bit er0, er1, dv0, dv1;
    er0 = (q0.size() != 4);
    dv0 = (q0.size() != 0);
    er1 = (q1.size() != 4);
    dv1 = (q1.size() != 0);
    h0 = 44'h0;
    h1 = 44'h0;
    if (dv0) h0 = q0[0];
    if (dv1) h1 = q1[0];
    chk("sb_rdy0", 64'(bus.enq_rdy_d0), 64'(er0));
    chk("sb_val0", 64'(bus.deq_val_d0), 64'(dv0));
    chk("sb_msg0", 64'(bus.deq_msg_d0), 64'(h0));
    chk("sb_dest0", 64'(bus.deq_dest_d0), 64'(h0[43:41]));
    chk("sb_rdy1", 64'(bus.enq_rdy_d1), 64'(er1));
    chk("sb_val1", 64'(bus.deq_val_d1), 64'(dv1));
    chk("sb_msg1", 64'(bus.deq_msg_d1), 64'(h1));
    chk("sb_dest1", 64'(bus.deq_dest_d1), 64'(h1[43:41]));
    if (rec == 1) tr_a[idx] = bus.enq_rdy_d0;
    if (rec == 2) tr_b[idx] = bus.enq_rdy_d0;
    tag++;
    m0 = mk($urandom_range(7, 0), tag);
    tag++;
    m1 = mk($urandom_range(7, 0), tag);
    bus.enq_val_d0 = ev0;
    bus.enq_msg_d0 = m0;
    bus.deq_rdy_d0 = dr0;
    bus.enq_val_d1 = ev1;
    bus.enq_msg_d1 = m1;
    bus.deq_rdy_d1 = dr1;
    if (ev0 && er0) q0.push_back(m0);
    if (dr0 && dv0) void'(q0.pop_front());
    if (ev1 && er1) q1.push_back(m1);
    if (dr1 && dv1) void'(q1.pop_front());
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    bus.enq_msg_d0 = 44'h0;
    bus.enq_val_d0 = 1'b0;
    bus.deq_rdy_d0 = 1'b0;
    bus.enq_msg_d1 = 44'h0;
    bus.enq_val_d1 = 1'b0;
    bus.deq_rdy_d1 = 1'b0;

    // reset state, then idle
    @(negedge clk);
    chk("rst_rdy0", 64'(bus.enq_rdy_d0), 64'd1);
    chk("rst_rdy1", 64'(bus.enq_rdy_d1), 64'd1);
    chk("rst_val0", 64'(bus.deq_val_d0), 64'd0);
    chk("rst_val1", 64'(bus.deq_val_d1), 64'd0);
    chk("rst_msg0", 64'(bus.deq_msg_d0), 64'd0);
    chk("rst_dest1", 64'(bus.deq_dest_d1), 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_rdy0", 64'(bus.enq_rdy_d0), 64'd1);
      chk("idle_rdy1", 64'(bus.enq_rdy_d1), 64'd1);
      chk("idle_val0", 64'(bus.deq_val_d0), 64'd0);
      chk("idle_val1", 64'(bus.deq_val_d1), 64'd0);
      chk("idle_msg0", 64'(bus.deq_msg_d0), 64'd0);
      chk("idle_msg1", 64'(bus.deq_msg_d1), 64'd0);
    end

    // d0 ordering and one-cycle latency
    bus.enq_val_d0 = 1'b1;
    bus.enq_msg_d0 = mk(3, 1);
    chk("lat_val_pre", 64'(bus.deq_val_d0), 64'd0);
    @(negedge clk);
    chk("lat_val", 64'(bus.deq_val_d0), 64'd1);
    chk("lat_dest", 64'(bus.deq_dest_d0), 64'd3);
    bus.enq_msg_d0 = mk(5, 2);
    @(negedge clk);
    chk("hold_dest_a", 64'(bus.deq_dest_d0), 64'd3);
    bus.enq_msg_d0 = mk(7, 3);
    @(negedge clk);
    bus.enq_val_d0 = 1'b0;
    chk("hold_dest_b", 64'(bus.deq_dest_d0), 64'd3);
    chk("hold_msg", 64'(bus.deq_msg_d0), 64'(mk(3, 1)));
    chk("three_rdy0", 64'(bus.enq_rdy_d0), 64'd1);
    bus.deq_rdy_d0 = 1'b1;
    @(negedge clk);
    chk("order_dest5", 64'(bus.deq_dest_d0), 64'd5);
    @(negedge clk);
    chk("order_dest7", 64'(bus.deq_dest_d0), 64'd7);
    chk("order_msg7", 64'(bus.deq_msg_d0), 64'(mk(7, 3)));
    @(negedge clk);
    chk("drain_val0", 64'(bus.deq_val_d0), 64'd0);
    chk("drain_msg0", 64'(bus.deq_msg_d0), 64'd0);
    chk("drain_dest0", 64'(bus.deq_dest_d0), 64'd0);
    bus.deq_rdy_d0 = 1'b0;

    // fill d1; a message offered while full must never appear
    for (int i = 0; i < 4; i++) begin
      chk("fill_rdy1", 64'(bus.enq_rdy_d1), 64'd1);
      bus.enq_val_d1 = 1'b1;
      bus.enq_msg_d1 = mk(i + 1, 'h11 + i);
      @(negedge clk);
    end
    bus.enq_msg_d1 = mk(6, 'hbad);
    bus.enq_val_d0 = 1'b1;
    bus.enq_msg_d0 = mk(2, 'h21);
    chk("full_rdy1", 64'(bus.enq_rdy_d1), 64'd0);
    chk("full_rdy0", 64'(bus.enq_rdy_d0), 64'd1);
    @(negedge clk);
    bus.enq_val_d0 = 1'b0;
    chk("full_rdy1_b", 64'(bus.enq_rdy_d1), 64'd0);
    chk("full_rdy0_b", 64'(bus.enq_rdy_d0), 64'd1);
    chk("full_head1", 64'(bus.deq_msg_d1), 64'(mk(1, 'h11)));
    @(negedge clk);
    chk("full_rdy1_c", 64'(bus.enq_rdy_d1), 64'd0);
    bus.deq_rdy_d1 = 1'b1;
    chk("nopipe_rdy1", 64'(bus.enq_rdy_d1), 64'd0);
    @(negedge clk);
    bus.enq_val_d1 = 1'b0;
    chk("after_pop_rdy1", 64'(bus.enq_rdy_d1), 64'd1);
    chk("d1_head2", 64'(bus.deq_msg_d1), 64'(mk(2, 'h12)));
    @(negedge clk);
    chk("d1_head3", 64'(bus.deq_msg_d1), 64'(mk(3, 'h13)));
    @(negedge clk);
    chk("d1_head4", 64'(bus.deq_msg_d1), 64'(mk(4, 'h14)));
    @(negedge clk);
    chk("d1_empty", 64'(bus.deq_val_d1), 64'd0);
    chk("d1_empty_msg", 64'(bus.deq_msg_d1), 64'd0);
    bus.deq_rdy_d1 = 1'b0;
    chk("d0_side_msg", 64'(bus.deq_msg_d0), 64'(mk(2, 'h21)));
    chk("d0_side_dest", 64'(bus.deq_dest_d0), 64'd2);
    bus.deq_rdy_d0 = 1'b1;
    @(negedge clk);
    chk("d0_side_empty", 64'(bus.deq_val_d0), 64'd0);
    bus.deq_rdy_d0 = 1'b0;

    // steady state of two entries on d0 with wrap-around
    bus.enq_val_d0 = 1'b1;
    bus.enq_msg_d0 = mk(0, 'h100);
    @(negedge clk);
    bus.enq_msg_d0 = mk(1, 'h101);
    chk("ss_first", 64'(bus.deq_msg_d0), 64'(mk(0, 'h100)));
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      chk("ss_head", 64'(bus.deq_msg_d0), 64'(mk(k % 8, 'h100 + k)));
      chk("ss_rdy0", 64'(bus.enq_rdy_d0), 64'd1);
      bus.enq_msg_d0 = mk((k + 2) % 8, 'h100 + k + 2);
      bus.deq_rdy_d0 = 1'b1;
      @(negedge clk);
    end
    bus.enq_val_d0 = 1'b0;
    chk("ss_tail20", 64'(bus.deq_msg_d0), 64'(mk(4, 'h114)));
    @(negedge clk);
    chk("ss_tail21", 64'(bus.deq_msg_d0), 64'(mk(5, 'h115)));
    @(negedge clk);
    chk("ss_empty", 64'(bus.deq_val_d0), 64'd0);
    bus.deq_rdy_d0 = 1'b0;

    // interleaved traffic; d0 ready trace must not depend on d1 load
    for (int i = 0; i < 40; i++) begin
      p_ev0[i] = ($urandom_range(2, 0) != 0);
      p_dr0[i] = ($urandom_range(2, 0) == 0);
    end
    for (int i = 0; i < 40; i++) step2(p_ev0[i], p_dr0[i], 1'b0, 1'b0, i, 1);
    for (int i = 0; i < 8; i++) step2(1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 40; i++) step2(p_ev0[i], p_dr0[i], 1'b1, 1'($urandom_range(1, 0)), i, 2);
    for (int i = 0; i < 8; i++) step2(1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    chk("iso_trace", 64'(tr_b), 64'(tr_a));

    // asynchronous reset with three entries queued and a dequeue in flight
    for (int i = 0; i < 3; i++) step2(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    bus.enq_val_d0 = 1'b0;
    bus.enq_val_d1 = 1'b0;
    bus.deq_rdy_d0 = 1'b1;
    chk("pre_rst_val0", 64'(bus.deq_val_d0), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_val0", 64'(bus.deq_val_d0), 64'd0);
    chk("arst_val1", 64'(bus.deq_val_d1), 64'd0);
    chk("arst_rdy0", 64'(bus.enq_rdy_d0), 64'd1);
    chk("arst_msg0", 64'(bus.deq_msg_d0), 64'd0);
    q0.delete();
    q1.delete();
    bus.deq_rdy_d0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step2(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step2(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step2(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    step2(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
